// File: rtl/sw_alloc.sv
// sw_alloc: wormhole switch allocator for the 5-port router.
// Each output has a round-robin arbiter. A packet's head flit locks the output
// to its input until the tail flit passes. The allocator produces the buffer
// pops (grant), per-output valid and the 20-bit crossbar select word (func).
// Optional feature macro: SA_STALL_CNT_EN adds per-output stall counters on
// port stall_cnt.
module sw_alloc
`ifdef SA_STALL_CNT_EN
#(
    parameter int CNT_W = 16
)
`endif
(
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  req_valid,
    input  logic [14:0] req_dest,
    input  logic [4:0]  req_tail,
    input  logic [4:0]  out_ready,
    output logic [4:0]  grant,
    output logic [4:0]  out_valid,
    output logic [19:0] func,
    output logic [4:0]  err
`ifdef SA_STALL_CNT_EN
    ,
    output logic [5*CNT_W-1:0] stall_cnt
`endif
);

    localparam int NPORT = 5;

    // Per-output lock state and round-robin pointers, plus per-input sticky errors.
    logic [NPORT-1:0]      r_lock;
    logic [2:0]            r_owner [NPORT];
    logic [2:0]            r_ptr   [NPORT];
    logic [NPORT-1:0]      r_err;

    logic [2:0]            w_dest  [NPORT];
    logic [NPORT-1:0]      w_legal;
    logic [NPORT-1:0]      w_illegal;
    logic [NPORT-1:0]      w_misroute;
    // Each of these is indexed [output][input].
    logic [NPORT-1:0][NPORT-1:0] w_reqLegal;
    logic [NPORT-1:0][NPORT-1:0] w_reqFor;
    logic [NPORT-1:0][NPORT-1:0] w_gnt;
    logic [NPORT-1:0]      w_rrHit;
    logic [2:0]            w_rrWin [NPORT];
    logic [NPORT-1:0]      w_gntTail;
    logic [NPORT-1:0]      w_grant;
    logic [NPORT-1:0]      w_outValid;
    logic [19:0]           w_func;

    // Position 'off' steps past 'base' in the circular order 0..4.
    function automatic logic [2:0] rrIdx(input logic [2:0] base, input logic [2:0] off);
        logic [3:0] s;
        s = {1'b0, base} + {1'b0, off};
        if (s >= 4'd5) begin
            return 3'(s - 4'd5);
        end
        return s[2:0];
    endfunction

    // Decode each input's destination and classify it as legal or illegal.
    always_comb begin
        w_legal   = '0;
        w_illegal = '0;
        for (int i = 0; i < NPORT; i++) begin
            w_dest[i] = req_dest[3*i +: 3];
            if (req_valid[i]) begin
                if (w_dest[i] <= 3'd4 && w_dest[i] != 3'(i)) begin
                    w_legal[i] = 1'b1;
                end else begin
                    w_illegal[i] = 1'b1;
                end
            end
        end
    end

    // Flag lock owners that are requesting a different output while their lock is held.
    always_comb begin
        w_misroute = '0;
        for (int d = 0; d < NPORT; d++) begin
            for (int i = 0; i < NPORT; i++) begin
                if (r_lock[d] && r_owner[d] == 3'(i) && req_valid[i] && w_dest[i] != 3'(d)) begin
                    w_misroute[i] = 1'b1;
                end
            end
        end
    end

    // Build the request matrices. A misrouting owner is blocked from every output.
    always_comb begin
        w_reqLegal = '0;
        w_reqFor   = '0;
        for (int d = 0; d < NPORT; d++) begin
            for (int i = 0; i < NPORT; i++) begin
                if (w_legal[i] && w_dest[i] == 3'(d)) begin
                    w_reqLegal[d][i] = 1'b1;
                    w_reqFor[d][i]   = !w_misroute[i];
                end
            end
        end
    end

    // For each output, take the first requester found by scanning up from ptr; the output's own index is skipped.
    always_comb begin
        for (int d = 0; d < NPORT; d++) begin
            w_rrHit[d] = 1'b0;
            w_rrWin[d] = 3'd0;
            for (int k = 0; k < NPORT; k++) begin
                if (!w_rrHit[d] && rrIdx(r_ptr[d], 3'(k)) != 3'(d)
                    && w_reqFor[d][rrIdx(r_ptr[d], 3'(k))]) begin
                    w_rrHit[d] = 1'b1;
                    w_rrWin[d] = rrIdx(r_ptr[d], 3'(k));
                end
            end
        end
    end

    // Issue grants. A locked output serves only its owner; an unlocked output serves the round-robin winner. Reset forces all grants to zero.
    always_comb begin
        w_gnt = '0;
        for (int d = 0; d < NPORT; d++) begin
            if (r_lock[d]) begin
                if (out_ready[d] && w_reqFor[d][r_owner[d]]) begin
                    w_gnt[d][r_owner[d]] = 1'b1;
                end
            end else if (out_ready[d] && w_rrHit[d]) begin
                w_gnt[d][w_rrWin[d]] = 1'b1;
            end
        end
        if (rst) begin
            w_gnt = '0;
        end
    end

    // Derive the pop vector, per-output valid, tail detection and the crossbar select word from the grant matrix.
    always_comb begin
        w_grant    = '0;
        w_outValid = '0;
        w_gntTail  = '0;
        w_func     = '0;
        for (int d = 0; d < NPORT; d++) begin
            w_outValid[d] = |w_gnt[d];
            w_gntTail[d]  = |(w_gnt[d] & req_tail);
            for (int s = 0; s < NPORT; s++) begin
                if (w_gnt[d][s]) begin
                    w_grant[s] = 1'b1;
                    w_func[4*s + ((d == 4) ? s : d)] = 1'b1;
                end
            end
        end
    end

    assign grant     = w_grant;
    assign out_valid = w_outValid;
    assign func      = w_func;
    assign err       = r_err;

    // Update the locks, owners, round-robin pointers and sticky error flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lock <= '0;
            r_err  <= '0;
            for (int d = 0; d < NPORT; d++) begin
                r_owner[d] <= 3'd0;
                r_ptr[d]   <= 3'd0;
            end
        end else begin
            for (int d = 0; d < NPORT; d++) begin
                if (r_lock[d]) begin
                    if (w_gntTail[d]) begin
                        r_lock[d] <= 1'b0;
                    end
                end else if (w_outValid[d]) begin
                    r_ptr[d] <= (w_rrWin[d] == 3'd4) ? 3'd0 : w_rrWin[d] + 3'd1;
                    if (!w_gntTail[d]) begin
                        r_lock[d]  <= 1'b1;
                        r_owner[d] <= w_rrWin[d];
                    end
                end
            end
            r_err <= r_err | w_illegal | w_misroute;
        end
    end

`ifdef SA_STALL_CNT_EN
    logic [CNT_W-1:0] r_stall [NPORT];

    // Count cycles in which an output has legal demand but moves no flit; each counter saturates at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int d = 0; d < NPORT; d++) begin
                r_stall[d] <= '0;
            end
        end else begin
            for (int d = 0; d < NPORT; d++) begin
                if ((|w_reqLegal[d]) && !w_outValid[d] && r_stall[d] != {CNT_W{1'b1}}) begin
                    r_stall[d] <= r_stall[d] + CNT_W'(1);
                end
            end
        end
    end

    // Flatten the counters onto the output port.
    always_comb begin
        stall_cnt = '0;
        for (int d = 0; d < NPORT; d++) begin
            stall_cnt[CNT_W*d +: CNT_W] = r_stall[d];
        end
    end
`endif

endmodule

// File: tb/tb_sw_alloc.sv
// tb_sw_alloc: table-driven bench for the wormhole switch allocator.
// Most of the test is a table of per-cycle vectors. The vectors share allocator
// state, so each row relies on the rows before it. Hand-written sequences then
// cover reset arriving mid-packet and the optional stall counters
// (SA_STALL_CNT_EN).
module tb_sw_alloc;

    logic        clk;
    logic        rst;
    logic [4:0]  req_valid;
    logic [14:0] req_dest;
    logic [4:0]  req_tail;
    logic [4:0]  out_ready;
    logic [4:0]  grant;
    logic [4:0]  out_valid;
    logic [19:0] func;
    logic [4:0]  err;
`ifdef SA_STALL_CNT_EN
    logic [79:0] stall_cnt;
`endif

    int checks;
    int failures;

    typedef struct {
        logic [4:0]  valid;
        logic [14:0] dest;
        logic [4:0]  tail;
        logic [4:0]  ready;
        logic [4:0]  expGrant;
        logic [4:0]  expValid;
        logic [19:0] expFunc;
        logic [4:0]  expErr;
    } vec_t;

    vec_t vecs[$];

    sw_alloc dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_dest(req_dest),
        .req_tail(req_tail),
        .out_ready(out_ready),
        .grant(grant),
        .out_valid(out_valid),
        .func(func),
        .err(err)
`ifdef SA_STALL_CNT_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    // Free-running clock with a 10-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Pack the destination fields for inputs 0..4.
    function automatic logic [14:0] pk(input int d0, input int d1, input int d2, input int d3, input int d4);
        return {3'(d4), 3'(d3), 3'(d2), 3'(d1), 3'(d0)};
    endfunction

    function automatic void addVec(input logic [4:0] v, input logic [14:0] d, input logic [4:0] t,
                                   input logic [4:0] r, input logic [4:0] g, input logic [4:0] ov,
                                   input logic [19:0] f, input logic [4:0] e);
        vec_t x;
        x.valid = v; x.dest = d; x.tail = t; x.ready = r;
        x.expGrant = g; x.expValid = ov; x.expFunc = f; x.expErr = e;
        vecs.push_back(x);
    endfunction

    // Drive the inputs just after the falling edge, then wait until mid-phase so the combinational outputs can be sampled.
    task automatic applyStimulus(input logic [4:0] v, input logic [14:0] d, input logic [4:0] t, input logic [4:0] r);
        @(negedge clk);
        req_valid = v;
        req_dest  = d;
        req_tail  = t;
        out_ready = r;
        #2;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Main test: the reset state, the vector table, then the hand-written corner cases.
    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        req_valid = '0;
        req_dest  = '0;
        req_tail  = '0;
        out_ready = '0;

        // Columns: valid, dest, tail, ready -> grant, out_valid, func, err
        // Single flit from input 0 to the local output 4; it must not lock the output.
        addVec(5'b00001, pk(4,0,0,0,0), 5'b00001, 5'h1F, 5'b00001, 5'b10000, 20'h00001, 5'b00000);
        addVec(5'b00100, pk(0,0,4,0,0), 5'b00100, 5'h1F, 5'b00100, 5'b10000, 20'h00400, 5'b00000);
        // Round robin on output 0 among inputs 1, 2 and 3.
        addVec(5'b01110, pk(0,0,0,0,0), 5'b01110, 5'h1F, 5'b00010, 5'b00001, 20'h00010, 5'b00000);
        addVec(5'b01110, pk(0,0,0,0,0), 5'b01110, 5'h1F, 5'b00100, 5'b00001, 20'h00100, 5'b00000);
        addVec(5'b01110, pk(0,0,0,0,0), 5'b01110, 5'h1F, 5'b01000, 5'b00001, 20'h01000, 5'b00000);
        addVec(5'b01110, pk(0,0,0,0,0), 5'b01110, 5'h1F, 5'b00010, 5'b00001, 20'h00010, 5'b00000);
        // Wormhole: a 3-flit packet from input 4 to output 2, with input 0 contending from the second flit on.
        addVec(5'b10000, pk(0,0,0,0,2), 5'b00000, 5'h1F, 5'b10000, 5'b00100, 20'h40000, 5'b00000);
        addVec(5'b10001, pk(2,0,0,0,2), 5'b00001, 5'h1F, 5'b10000, 5'b00100, 20'h40000, 5'b00000);
        addVec(5'b10001, pk(2,0,0,0,2), 5'b10001, 5'h1F, 5'b10000, 5'b00100, 20'h40000, 5'b00000);
        addVec(5'b00001, pk(2,0,0,0,0), 5'b00001, 5'h1F, 5'b00001, 5'b00100, 20'h00004, 5'b00000);
        // Backpressure mid-packet: output 2 is not ready for 4 cycles, then a bubble with the lock still held, then the owner resumes.
        addVec(5'b10000, pk(0,0,0,0,2), 5'b00000, 5'h1F, 5'b10000, 5'b00100, 20'h40000, 5'b00000);
        for (int k = 0; k < 4; k++) begin
            addVec(5'b10001, pk(2,0,0,0,2), 5'b00001, 5'b11011, 5'b00000, 5'b00000, 20'h00000, 5'b00000);
        end
        addVec(5'b00001, pk(2,0,0,0,0), 5'b00001, 5'h1F, 5'b00000, 5'b00000, 20'h00000, 5'b00000);
        addVec(5'b10001, pk(2,0,0,0,2), 5'b10001, 5'h1F, 5'b10000, 5'b00100, 20'h40000, 5'b00000);
        addVec(5'b00001, pk(2,0,0,0,0), 5'b00001, 5'h1F, 5'b00001, 5'b00100, 20'h00004, 5'b00000);
        // Illegal requests: input 3 targets itself, input 1 targets nonexistent port 6.
        addVec(5'b01000, pk(0,0,0,3,0), 5'b01000, 5'h1F, 5'b00000, 5'b00000, 20'h00000, 5'b00000);
        addVec(5'b00010, pk(0,6,0,0,0), 5'b00010, 5'h1F, 5'b00000, 5'b00000, 20'h00000, 5'b01000);
        addVec(5'b00000, pk(0,0,0,0,0), 5'b00000, 5'h1F, 5'b00000, 5'b00000, 20'h00000, 5'b01010);
        // Misroute: input 2 holds output 3, then asks for output 1 while the lock is held.
        addVec(5'b00100, pk(0,0,3,0,0), 5'b00000, 5'h1F, 5'b00100, 5'b01000, 20'h00800, 5'b01010);
        addVec(5'b00100, pk(0,0,1,0,0), 5'b00000, 5'h1F, 5'b00000, 5'b00000, 20'h00000, 5'b01010);
        addVec(5'b00101, pk(3,0,3,0,0), 5'b00101, 5'h1F, 5'b00100, 5'b01000, 20'h00800, 5'b01110);
        addVec(5'b00001, pk(3,0,0,0,0), 5'b00001, 5'h1F, 5'b00001, 5'b01000, 20'h00008, 5'b01110);
        // Three outputs granted in the same cycle, then a request to an output that is not ready.
        addVec(5'b01011, pk(1,0,0,4,0), 5'b01011, 5'h1F, 5'b01011, 5'b10011, 20'h08012, 5'b01110);
        addVec(5'b00010, pk(0,2,0,0,0), 5'b00010, 5'b11011, 5'b00000, 5'b00000, 20'h00000, 5'b01110);

        // Reset state: a live request must not be granted while rst is high.
        applyStimulus(5'b00001, pk(4,0,0,0,0), 5'b00001, 5'h1F);
        checkOutput("reset_grant", 32'(grant), 32'h0);
        checkOutput("reset_out_valid", 32'(out_valid), 32'h0);
        checkOutput("reset_func", 32'(func), 32'h0);
        checkOutput("reset_err", 32'(err), 32'h0);
        req_valid = '0;
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[n]) begin
            applyStimulus(vecs[n].valid, vecs[n].dest, vecs[n].tail, vecs[n].ready);
            checkOutput($sformatf("v%0d_grant", n), 32'(grant), 32'(vecs[n].expGrant));
            checkOutput($sformatf("v%0d_out_valid", n), 32'(out_valid), 32'(vecs[n].expValid));
            checkOutput($sformatf("v%0d_func", n), 32'(func), 32'(vecs[n].expFunc));
            checkOutput($sformatf("v%0d_err", n), 32'(err), 32'(vecs[n].expErr));
        end

        // Reset mid-packet: outputs drop as soon as rst rises, and afterwards a single flit to the same output is granted in its first cycle.
        @(negedge clk);
        req_valid = '0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rm_err_cleared", 32'(err), 32'h0);
        applyStimulus(5'b10000, pk(0,0,0,0,2), 5'b00000, 5'h1F);
        checkOutput("rm_head_grant", 32'(grant), 32'h10);
        applyStimulus(5'b10000, pk(0,0,0,0,2), 5'b00000, 5'h1F);
        checkOutput("rm_body_grant", 32'(grant), 32'h10);
        #1 rst = 1'b1;
        #1;
        checkOutput("rm_async_grant", 32'(grant), 32'h0);
        checkOutput("rm_async_out_valid", 32'(out_valid), 32'h0);
        checkOutput("rm_async_func", 32'(func), 32'h0);
        @(negedge clk);
        req_valid = 5'b00010;
        req_dest  = pk(0,2,0,0,0);
        req_tail  = 5'b00010;
        out_ready = 5'h1F;
        rst = 1'b0;
        #2;
        checkOutput("rm_new_grant", 32'(grant), 32'h02);
        checkOutput("rm_new_out_valid", 32'(out_valid), 32'h04);
        checkOutput("rm_new_func", 32'(func), 32'h40);

`ifdef SA_STALL_CNT_EN
        // Stall counters: 4 backpressured cycles on output 2 must add exactly 4 to its counter.
        @(negedge clk);
        req_valid = '0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int d = 0; d < 5; d++) begin
            checkOutput($sformatf("st_reset_%0d", d), 32'(stall_cnt[16*d +: 16]), 32'h0);
        end
        applyStimulus(5'b10000, pk(0,0,0,0,2), 5'b00000, 5'h1F);
        checkOutput("st_head_grant", 32'(grant), 32'h10);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(5'b10000, pk(0,0,0,0,2), 5'b00000, 5'b11011);
            checkOutput($sformatf("st_stall_grant_%0d", k), 32'(grant), 32'h0);
        end
        applyStimulus(5'b10000, pk(0,0,0,0,2), 5'b10000, 5'h1F);
        checkOutput("st_resume_grant", 32'(grant), 32'h10);
        applyStimulus(5'b00000, pk(0,0,0,0,0), 5'b00000, 5'h1F);
        for (int d = 0; d < 5; d++) begin
            checkOutput($sformatf("st_count_%0d", d), 32'(stall_cnt[16*d +: 16]), (d == 2) ? 32'd4 : 32'd0);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
